calc_operand_stack: RTL and testbench

Parametrised operand store for the keypad calculator. It generalises the two-register V1/V2 scheme into a digit-entry register plus a DEPTH-deep operand stack. It adds configurable digit and operand widths, backspace, clear-entry, and full/underflow status. It sits between the keypad decoder and the arithmetic block. It drives the entry/display operand and the second operand, and takes the arithmetic result back on equals.

---
 rtl/calc_operand_stack.sv | 125 ++++++++++++
 tb/tb_calc_operand_stack.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/calc_operand_stack.sv
// Operand store for the keypad calculator: digit-entry register x plus a DEPTH-deep
// operand stack whose top feeds the arithmetic block as y.
module calc_operand_stack #(
    parameter  int DIGIT_W = 4,
    parameter  int NDIGITS = 4,
    parameter  int DEPTH   = 4,
    localparam int WIDTH   = DIGIT_W * NDIGITS,
    localparam int DW      = $clog2(DEPTH + 1),
    localparam int CW      = $clog2(NDIGITS + 1)
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    i_newhex,
    input  logic [DIGIT_W-1:0]      i_hexcode,
    input  logic                    i_newop,
    input  logic                    i_eq,
    input  logic                    i_bksp,
    input  logic                    i_clr,
    input  logic signed [WIDTH-1:0] i_answer,
    output logic signed [WIDTH-1:0] o_x_reg,
    output logic signed [WIDTH-1:0] o_y_reg,
    output logic [DW-1:0]           o_depth,
    output logic [CW-1:0]           o_digit_cnt,
    output logic                    o_flow,
    output logic                    o_entry_full,
    output logic                    o_ovf,
    output logic                    o_unf
);

    typedef enum logic {ENTRY = 1'b0, RESULT = 1'b1} state_t;

    state_t                        r_state, w_state_nxt;
    logic [WIDTH-1:0]              r_x, w_x_nxt;
    logic [DEPTH-1:0][WIDTH-1:0]   r_stack, w_stack_nxt;
    logic [DW-1:0]                 r_depth, w_depth_nxt;
    logic [CW-1:0]                 r_cnt, w_cnt_nxt;
    logic                          r_ovf, w_ovf_nxt;
    logic                          r_unf, w_unf_nxt;
    logic                          w_full;

    assign w_full = (r_cnt == CW'(NDIGITS));

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ENTRY;
            r_x     <= '0;
            r_stack <= '0;
            r_depth <= '0;
            r_cnt   <= '0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_x     <= w_x_nxt;
            r_stack <= w_stack_nxt;
            r_depth <= w_depth_nxt;
            r_cnt   <= w_cnt_nxt;
            r_ovf   <= w_ovf_nxt;
            r_unf   <= w_unf_nxt;
        end
    end

    // One event per cycle; the if/else chain encodes clr > eq > newop > bksp > newhex.
    always_comb begin
        w_state_nxt = r_state;
        w_x_nxt     = r_x;
        w_stack_nxt = r_stack;
        w_depth_nxt = r_depth;
        w_cnt_nxt   = r_cnt;
        w_ovf_nxt   = r_ovf;
        w_unf_nxt   = r_unf;
        if (i_clr) begin
            w_x_nxt     = '0;
            w_cnt_nxt   = '0;
            w_state_nxt = ENTRY;
        end else if (i_eq) begin
            w_x_nxt     = i_answer;
            w_cnt_nxt   = '0;
            w_state_nxt = RESULT;
            if (r_depth != '0) begin
                for (int i = 0; i < DEPTH - 1; i++)
                    w_stack_nxt[i] = r_stack[i+1];
                w_stack_nxt[DEPTH-1] = '0;
                w_depth_nxt = r_depth - DW'(1);
            end else begin
                w_unf_nxt = 1'b1;
            end
        end else if (i_newop) begin
            w_stack_nxt[0] = r_x;
            for (int i = 1; i < DEPTH; i++)
                w_stack_nxt[i] = r_stack[i-1];
            // A full stack keeps its depth; the oldest entry falls off the end.
            if (r_depth == DW'(DEPTH))
                w_ovf_nxt = 1'b1;
            else
                w_depth_nxt = r_depth + DW'(1);
            w_cnt_nxt   = '0;
            w_state_nxt = RESULT;
        end else if (i_bksp) begin
            if (r_state == ENTRY && r_cnt != '0) begin
                w_x_nxt   = r_x >> DIGIT_W;
                w_cnt_nxt = r_cnt - CW'(1);
            end
        end else if (i_newhex) begin
            if (r_state == RESULT) begin
                w_x_nxt     = WIDTH'(i_hexcode);
                w_cnt_nxt   = CW'(1);
                w_state_nxt = ENTRY;
            end else if (!w_full) begin
                w_x_nxt   = (r_x << DIGIT_W) | WIDTH'(i_hexcode);
                w_cnt_nxt = r_cnt + CW'(1);
            end
        end
    end

    assign o_x_reg      = r_x;
    assign o_y_reg      = (r_depth != '0) ? r_stack[0] : '0;
    assign o_depth      = r_depth;
    assign o_digit_cnt  = r_cnt;
    assign o_flow       = (r_state == RESULT);
    assign o_entry_full = w_full;
    assign o_ovf        = r_ovf;
    assign o_unf        = r_unf;

endmodule

// File: tb/tb_calc_operand_stack.sv
// Bench for calc_operand_stack: directed scenarios plus random pulses against a
// queue-based model of the calculator's operand store.
module tb_calc_operand_stack;

    localparam int DEPTH   = 4;
    localparam int NDIGITS = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        newhex = 1'b0, newop = 1'b0, eq = 1'b0, bksp = 1'b0, clr = 1'b0;
    logic [3:0]  hexcode = '0;
    logic [15:0] answer = '0;
    logic signed [15:0] x_reg, y_reg;
    logic [2:0]  depth, digit_cnt;
    logic        flow, entry_full, ovf, unf;

    int n_checks = 0;
    int n_errors = 0;

    // reference model
    logic [15:0] m_x;
    logic [15:0] m_q[$];
    int          m_cnt;
    bit          m_flow, m_ovf, m_unf;

    calc_operand_stack #(.DIGIT_W(4), .NDIGITS(NDIGITS), .DEPTH(DEPTH)) dut (
        .clock(clock), .reset(reset),
        .i_newhex(newhex), .i_hexcode(hexcode), .i_newop(newop), .i_eq(eq),
        .i_bksp(bksp), .i_clr(clr), .i_answer(answer),
        .o_x_reg(x_reg), .o_y_reg(y_reg), .o_depth(depth), .o_digit_cnt(digit_cnt),
        .o_flow(flow), .o_entry_full(entry_full), .o_ovf(ovf), .o_unf(unf)
    );

    always #5 clock = ~clock;

    function automatic logic [15:0] m_y();
        return (m_q.size() > 0) ? m_q[0] : 16'h0;
    endfunction

    task automatic m_reset();
        m_x = 0; m_q.delete(); m_cnt = 0; m_flow = 0; m_ovf = 0; m_unf = 0;
    endtask

    task automatic m_apply(input bit c, input bit e, input bit o, input bit b,
                           input bit h, input logic [3:0] hv, input logic [15:0] ans);
        if (c) begin
            m_x = 0; m_cnt = 0; m_flow = 0;
        end else if (e) begin
            m_x = ans; m_cnt = 0; m_flow = 1;
            if (m_q.size() > 0) void'(m_q.pop_front());
            else m_unf = 1;
        end else if (o) begin
            m_q.push_front(m_x);
            if (m_q.size() > DEPTH) begin void'(m_q.pop_back()); m_ovf = 1; end
            m_cnt = 0; m_flow = 1;
        end else if (b) begin
            if (!m_flow && m_cnt > 0) begin m_x = m_x / 16; m_cnt--; end
        end else if (h) begin
            if (m_flow) begin m_x = {12'h0, hv}; m_cnt = 1; m_flow = 0; end
            else if (m_cnt < NDIGITS) begin m_x = m_x * 16 + {12'h0, hv}; m_cnt++; end
        end
    endtask

    // One clock with the given pulses; outputs are then sampled 1 time unit past the edge.
    task automatic step(input bit c, input bit e, input bit o, input bit b,
                        input bit h, input logic [3:0] hv, input logic [15:0] ans);
        clr = c; eq = e; newop = o; bksp = b; newhex = h; hexcode = hv; answer = ans;
        @(posedge clock); #1;
        clr = 0; eq = 0; newop = 0; bksp = 0; newhex = 0;
        m_apply(c, e, o, b, h, hv, ans);
    endtask

    task automatic hex(input logic [3:0] v);  step(0, 0, 0, 0, 1, v, 16'h0); endtask
    task automatic do_reset();
        reset = 1; @(posedge clock); #1; reset = 0; m_reset();
    endtask

    task automatic test_reset();
        hex(4'h3); step(0, 0, 1, 0, 0, 0, 0);
        do_reset();
        n_checks++; if ({x_reg, y_reg, depth, digit_cnt, flow, entry_full, ovf, unf} !== '0) begin
            n_errors++; $display("FAIL reset_state: x=%h y=%h depth=%0d cnt=%0d flow=%b full=%b ovf=%b unf=%b, required all 0",
                                 x_reg, y_reg, depth, digit_cnt, flow, entry_full, ovf, unf);
        end
    endtask

    task automatic test_entry_full();
        do_reset();
        hex(4'h1); hex(4'h2); hex(4'h3); hex(4'h4);
        n_checks++; if (x_reg !== 16'h1234 || digit_cnt !== 3'd4 || entry_full !== 1'b1) begin
            n_errors++; $display("FAIL entry_4digits: x=%h cnt=%0d full=%b, required 1234 4 1", x_reg, digit_cnt, entry_full);
        end
        hex(4'h5);
        n_checks++; if (x_reg !== 16'h1234 || digit_cnt !== 3'd4) begin
            n_errors++; $display("FAIL entry_5th_ignored: x=%h cnt=%0d, required 1234 4", x_reg, digit_cnt);
        end
    endtask

    task automatic test_bksp();
        step(1, 0, 0, 0, 0, 0, 0);
        hex(4'hA); hex(4'hB);
        n_checks++; if (x_reg !== 16'h00AB) begin
            n_errors++; $display("FAIL bksp_setup: x=%h, required 00ab", x_reg);
        end
        step(0, 0, 0, 1, 0, 0, 0);
        n_checks++; if (x_reg !== 16'h000A || digit_cnt !== 3'd1) begin
            n_errors++; $display("FAIL bksp_one: x=%h cnt=%0d, required 000a 1", x_reg, digit_cnt);
        end
        step(0, 0, 0, 1, 0, 0, 0); step(0, 0, 0, 1, 0, 0, 0);
        n_checks++; if (x_reg !== 16'h0 || digit_cnt !== 3'd0 || flow !== 1'b0) begin
            n_errors++; $display("FAIL bksp_empty: x=%h cnt=%0d flow=%b, required 0 0 0", x_reg, digit_cnt, flow);
        end
    endtask

    task automatic test_push_eq();
        step(1, 0, 0, 0, 0, 0, 0);
        hex(4'h7); step(0, 0, 1, 0, 0, 0, 0); hex(4'h3);
        n_checks++; if (y_reg !== 16'sd7 || x_reg !== 16'sd3 || depth !== 3'd1) begin
            n_errors++; $display("FAIL push_one: y=%h x=%h depth=%0d, required 7 3 1", y_reg, x_reg, depth);
        end
        step(0, 1, 0, 0, 0, 0, 16'h000A);
        n_checks++; if (x_reg !== 16'h000A || depth !== 3'd0 || y_reg !== 16'h0 || flow !== 1'b1) begin
            n_errors++; $display("FAIL eq_pop: x=%h depth=%0d y=%h flow=%b, required 000a 0 0 1", x_reg, depth, y_reg, flow);
        end
        hex(4'h2);
        n_checks++; if (x_reg !== 16'h0002 || flow !== 1'b0 || digit_cnt !== 3'd1) begin
            n_errors++; $display("FAIL new_entry_after_eq: x=%h flow=%b cnt=%0d, required 0002 0 1", x_reg, flow, digit_cnt);
        end
    endtask

    task automatic test_overflow();
        logic [15:0] exp_y[4];
        exp_y[0] = 16'd4; exp_y[1] = 16'd3; exp_y[2] = 16'd2; exp_y[3] = 16'd0;
        do_reset();
        for (int v = 1; v <= 5; v++) begin hex(4'(v)); step(0, 0, 1, 0, 0, 0, 0); end
        n_checks++; if (depth !== 3'd4 || ovf !== 1'b1 || y_reg !== 16'sd5) begin
            n_errors++; $display("FAIL overflow_push: depth=%0d ovf=%b y=%h, required 4 1 5", depth, ovf, y_reg);
        end
        for (int k = 0; k < 4; k++) begin
            step(0, 1, 0, 0, 0, 0, 16'h0);
            n_checks++; if (y_reg !== exp_y[k] || depth !== 3'(3 - k)) begin
                n_errors++; $display("FAIL overflow_pop%0d: y=%h depth=%0d, required %h %0d", k, y_reg, depth, exp_y[k], 3 - k);
            end
        end
    endtask

    task automatic test_underflow_clr();
        do_reset();
        step(0, 1, 0, 0, 0, 0, 16'hFFFE);
        n_checks++; if (x_reg !== 16'hFFFE || x_reg != -16'sd2 || unf !== 1'b1 || depth !== 3'd0) begin
            n_errors++; $display("FAIL underflow: x=%h unf=%b depth=%0d, required fffe 1 0", x_reg, unf, depth);
        end
        step(1, 0, 0, 0, 0, 0, 0);
        n_checks++; if (x_reg !== 16'h0 || unf !== 1'b1 || flow !== 1'b0) begin
            n_errors++; $display("FAIL clr_keeps_unf: x=%h unf=%b flow=%b, required 0 1 0", x_reg, unf, flow);
        end
        do_reset();
        n_checks++; if (unf !== 1'b0) begin
            n_errors++; $display("FAIL reset_clears_unf: unf=%b, required 0", unf);
        end
    endtask

    task automatic test_priority();
        do_reset();
        hex(4'h6);
        step(0, 0, 1, 0, 1, 4'h9, 0);
        n_checks++; if (x_reg !== 16'h6 || depth !== 3'd1 || y_reg !== 16'h6 || flow !== 1'b1) begin
            n_errors++; $display("FAIL newop_over_newhex: x=%h depth=%0d y=%h flow=%b, required 6 1 6 1", x_reg, depth, y_reg, flow);
        end
        step(1, 1, 0, 0, 0, 0, 16'h1111);
        n_checks++; if (x_reg !== 16'h0 || depth !== 3'd1 || unf !== 1'b0 || flow !== 1'b0) begin
            n_errors++; $display("FAIL clr_over_eq: x=%h depth=%0d unf=%b flow=%b, required 0 1 0 0", x_reg, depth, unf, flow);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 600; n++) begin
            step($urandom_range(0, 15) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0,
                 $urandom_range(0, 4) == 0, $urandom_range(0, 1) == 1,
                 4'($urandom), 16'($urandom));
            n_checks++; if (x_reg !== m_x || y_reg !== m_y() || depth !== 3'(m_q.size()) ||
                            digit_cnt !== 3'(m_cnt) || flow !== m_flow ||
                            entry_full !== (m_cnt == NDIGITS) || ovf !== m_ovf || unf !== m_unf) begin
                n_errors++;
                $display("FAIL random_cycle%0d: x=%h y=%h d=%0d c=%0d f=%b o=%b u=%b, required x=%h y=%h d=%0d c=%0d f=%b o=%b u=%b",
                         n, x_reg, y_reg, depth, digit_cnt, flow, ovf, unf,
                         m_x, m_y(), m_q.size(), m_cnt, m_flow, m_ovf, m_unf);
            end
        end
    endtask

    initial begin
        m_reset();
        @(posedge clock); #1;
        test_reset();
        test_entry_full();
        test_bksp();
        test_push_eq();
        test_overflow();
        test_underflow_clr();
        test_priority();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
